// File: rtl/tc_pkg.sv
// Shared types and limits for the SRAM port arbiter.
package tc_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      OWN  = 1'b1
   } arb_state_t;

   localparam int ARB_MAX_REQ = 8;
   localparam int ARB_IDX_W   = $clog2(ARB_MAX_REQ);

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority one-hot picker: first masked request at or above ptr, wrapping to 0.
module rr_pick
   import tc_pkg::*;
#(
   parameter int N = 3
) (
   input  logic [N-1:0]         req,
   input  logic [ARB_IDX_W-1:0] ptr,
   input  logic [N-1:0]         mask,
   output logic [N-1:0]         onehot
);

   logic [N-1:0] cand;
   logic         found;

   assign cand = req & mask;

   // Two passes give the wrap: upper segment [ptr, N) first, then [0, ptr).
   always_comb begin
      onehot = '0;
      found  = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!found && cand[i] && (i >= int'(ptr))) begin
            onehot[i] = 1'b1;
            found     = 1'b1;
         end
      end
      for (int i = 0; i < N; i++) begin
         if (!found && cand[i] && (i < int'(ptr))) begin
            onehot[i] = 1'b1;
            found     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM among NUM_REQ requesters,
// with a per-owner burst limit and one-cycle read return.
//
//   state | meaning
//   IDLE  | no owner; any request is granted the same cycle
//   OWN   | owner register valid; owner keeps the port up to MAX_BURST beats
module sram_port_arbiter
   import tc_pkg::*;
#(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8,
   parameter int NUM_REQ    = 3,
   parameter int MAX_BURST  = 4
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [NUM_REQ-1:0]               req,
   input  logic [NUM_REQ-1:0]               we,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]    addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    wdata,
   output logic [NUM_REQ-1:0]               gnt,
   output logic [NUM_REQ-1:0]               rvalid,
   output logic [DATA_WIDTH-1:0]            rdata,
   output logic                             mem_cs,
   output logic                             mem_we,
   output logic [ADDR_WIDTH-1:0]            mem_addr,
   output logic [DATA_WIDTH-1:0]            mem_din,
   input  logic [DATA_WIDTH-1:0]            mem_dout
);

   localparam logic [3:0]           BURST_MAX = 4'(MAX_BURST);
   localparam logic [ARB_IDX_W-1:0] LAST_IDX  = ARB_IDX_W'(NUM_REQ - 1);

   arb_state_t           state, state_nxt;
   logic [ARB_IDX_W-1:0] owner, owner_nxt, owner_inc;
   logic [ARB_IDX_W-1:0] rr_ptr, rr_ptr_nxt;
   logic [ARB_IDX_W-1:0] pick_ptr, pick_idx;
   logic [3:0]           burst_cnt, burst_nxt;
   logic [NUM_REQ-1:0]   owner_oh, pick, pick_mask, gnt_c, rvalid_q;
   logic                 others;

   assign owner_inc = (owner == LAST_IDX) ? '0 : owner + 1'b1;

   always_comb begin
      owner_oh = '0;
      for (int i = 0; i < NUM_REQ; i++) owner_oh[i] = (owner == ARB_IDX_W'(i));
   end

   assign others = |(req & ~owner_oh);

   // One picker serves both cases: in OWN it scans from owner+1 with the owner masked.
   assign pick_ptr  = (state == OWN) ? owner_inc : rr_ptr;
   assign pick_mask = (state == OWN) ? ~owner_oh : '1;

   rr_pick #(.N(NUM_REQ)) u_rr_pick (
      .req    (req),
      .ptr    (pick_ptr),
      .mask   (pick_mask),
      .onehot (pick)
   );

   always_comb begin
      pick_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) if (pick[i]) pick_idx = ARB_IDX_W'(i);
   end

   always_comb begin
      state_nxt  = state;
      owner_nxt  = owner;
      rr_ptr_nxt = rr_ptr;
      burst_nxt  = burst_cnt;
      gnt_c      = '0;
      case (state)
         IDLE: begin
            if (|req) begin
               gnt_c     = pick;
               owner_nxt = pick_idx;
               burst_nxt = 4'd1;
               state_nxt = OWN;
            end
         end
         OWN: begin
            if (|(req & owner_oh)) begin
               if ((burst_cnt < BURST_MAX) || !others) begin
                  gnt_c = owner_oh;
                  if (burst_cnt < BURST_MAX) burst_nxt = burst_cnt + 4'd1;
               end else begin
                  rr_ptr_nxt = owner_inc;
                  gnt_c      = pick;
                  owner_nxt  = pick_idx;
                  burst_nxt  = 4'd1;
               end
            end else begin
               rr_ptr_nxt = owner_inc;
               if (|req) begin
                  gnt_c     = pick;
                  owner_nxt = pick_idx;
                  burst_nxt = 4'd1;
               end else begin
                  state_nxt = IDLE;
                  burst_nxt = '0;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Grant is combinational, so reset must also gate it to meet the async reset values.
   assign gnt    = rst_n ? gnt_c : '0;
   assign mem_cs = |gnt;

   always_comb begin
      mem_we   = 1'b0;
      mem_addr = '0;
      mem_din  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            mem_we   = we[i];
            mem_addr = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            mem_din  = wdata[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         owner     <= '0;
         rr_ptr    <= '0;
         burst_cnt <= '0;
         rvalid_q  <= '0;
      end else begin
         state     <= state_nxt;
         owner     <= owner_nxt;
         rr_ptr    <= rr_ptr_nxt;
         burst_cnt <= burst_nxt;
         rvalid_q  <= gnt & ~we;
      end
   end

   // SRAM output is already registered; only qualify it with the return pulse.
   assign rvalid = rvalid_q;
   assign rdata  = (|rvalid_q) ? mem_dout : '0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomised and directed bench for sram_port_arbiter against a rule-level arbitration model.
module tb_sram_port_arbiter;

   localparam int AW = 4;
   localparam int DW = 8;
   localparam int N  = 3;
   localparam int MB = 4;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req, we, gnt, rvalid;
   logic [N*AW-1:0] addr;
   logic [N*DW-1:0] wdata;
   logic [DW-1:0]   rdata, mem_din, mem_dout;
   logic            mem_cs, mem_we;
   logic [AW-1:0]   mem_addr;

   logic [DW-1:0]   sram    [16];
   logic [DW-1:0]   ref_mem [16];

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   int            m_owner, m_cnt, m_ptr, e_rv, last_g;
   logic [DW-1:0] e_rd;

   always #5 clk = ~clk;

   sram_port_arbiter #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .NUM_REQ    (N),
      .MAX_BURST  (MB)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .we       (we),
      .addr     (addr),
      .wdata    (wdata),
      .gnt      (gnt),
      .rvalid   (rvalid),
      .rdata    (rdata),
      .mem_cs   (mem_cs),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_din  (mem_din),
      .mem_dout (mem_dout)
   );

   always @(posedge clk) begin
      if (mem_cs) begin
         if (mem_we) sram[mem_addr] <= mem_din;
         else        mem_dout <= sram[mem_addr];
      end
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic int first_from(input logic [N-1:0] r, input int start, input int excl);
      for (int k = 0; k < N; k++) begin
         int idx;
         idx = (start + k) % N;
         if (r[idx] && idx != excl) return idx;
      end
      return -1;
   endfunction

   function automatic int any_other(input logic [N-1:0] r, input int own);
      for (int k = 0; k < N; k++) if (r[k] && k != own) return 1;
      return 0;
   endfunction

   task automatic model_reset();
      m_owner = -1;
      m_cnt   = 0;
      m_ptr   = 0;
      e_rv    = -1;
      e_rd    = '0;
      last_g  = -1;
   endtask

   // One clock: apply inputs, check combinational outputs, advance across the edge.
   task automatic drive_cycle(input logic [N-1:0] r, input logic [N-1:0] w,
                              input logic [N*AW-1:0] a, input logic [N*DW-1:0] d);
      int g, n_owner, n_cnt, n_ptr;
      logic [AW-1:0] ga;
      req = r; we = w; addr = a; wdata = d;
      #2;
      n_owner = m_owner; n_cnt = m_cnt; n_ptr = m_ptr; g = -1;
      if (m_owner < 0) begin
         g = first_from(r, m_ptr, -1);
         if (g >= 0) begin n_owner = g; n_cnt = 1; end
      end else if (r[m_owner]) begin
         if (m_cnt < MB || !any_other(r, m_owner)) begin
            g = m_owner;
            n_cnt = (m_cnt < MB) ? m_cnt + 1 : MB;
         end else begin
            n_ptr = (m_owner + 1) % N;
            g = first_from(r, n_ptr, m_owner);
            n_owner = g; n_cnt = 1;
         end
      end else begin
         n_ptr = (m_owner + 1) % N;
         g = first_from(r, n_ptr, -1);
         n_owner = g;
         n_cnt = (g >= 0) ? 1 : 0;
      end
      check("gnt", 32'(gnt), (g >= 0) ? (32'd1 << g) : 32'd0);
      check("mem_cs", 32'(mem_cs), (g >= 0) ? 32'd1 : 32'd0);
      if (g >= 0) begin
         check("mem_we", 32'(mem_we), 32'(w[g]));
         check("mem_addr", 32'(mem_addr), 32'(a[g*AW +: AW]));
         check("mem_din", 32'(mem_din), 32'(d[g*DW +: DW]));
      end
      check("rvalid", 32'(rvalid), (e_rv >= 0) ? (32'd1 << e_rv) : 32'd0);
      if (e_rv >= 0) check("rdata", 32'(rdata), 32'(e_rd));
      @(posedge clk);
      e_rv = -1;
      if (g >= 0) begin
         ga = a[g*AW +: AW];
         if (w[g]) ref_mem[ga] = d[g*DW +: DW];
         else begin
            e_rv = g;
            e_rd = ref_mem[ga];
         end
      end
      m_owner = n_owner; m_cnt = n_cnt; m_ptr = n_ptr; last_g = g;
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req = '0; we = '0; addr = '0; wdata = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      logic [N-1:0]    r, w;
      logic [N*AW-1:0] a;
      logic [N*DW-1:0] d;
      int              waited;

      for (int i = 0; i < 16; i++) begin
         sram[i]    = 8'($urandom);
         ref_mem[i] = sram[i];
      end
      mem_dout = '0;

      // reset values with requests already pending
      rst_n = 1'b0;
      req = 3'b111; we = '0; addr = {4'd3, 4'd2, 4'd1}; wdata = '0;
      model_reset();
      #3;
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_cs", 32'(mem_cs), 32'd0);
      check("rst_rvalid", 32'(rvalid), 32'd0);
      check("rst_rdata", 32'(rdata), 32'd0);
      check("rst_addr", 32'(mem_addr), 32'd0);
      do_reset();

      // all three read continuously: bursts of MB, rotating 0,1,2
      for (int k = 0; k < 12; k++) begin
         drive_cycle(3'b111, 3'b000, {4'd3, 4'd2, 4'd1}, '0);
         check("rr_seq", 32'(last_g), 32'(k / MB));
      end
      drive_cycle('0, '0, '0, '0);

      // lone requester is never rotated away
      do_reset();
      for (int k = 0; k < 10; k++) begin
         drive_cycle(3'b100, 3'b000, {4'd5, 4'd0, 4'd0}, '0);
         check("solo_gnt", 32'(last_g), 32'd2);
      end
      drive_cycle('0, '0, '0, '0);

      // write then read same address on consecutive beats
      do_reset();
      drive_cycle(3'b010, 3'b010, {4'd0, 4'd7, 4'd0}, {8'h00, 8'hA5, 8'h00});
      check("wr_no_rvalid", 32'(rvalid), 32'd0);
      drive_cycle(3'b001, 3'b000, {4'd0, 4'd0, 4'd7}, '0);
      req = '0;
      #1;
      check("raw_rvalid", 32'(rvalid), 32'd1);
      check("raw_rdata", 32'(rdata), 32'hA5);
      drive_cycle('0, '0, '0, '0);

      // owner drops after two beats, waiting requester takes over same cycle
      do_reset();
      drive_cycle(3'b101, 3'b000, {4'd2, 4'd0, 4'd1}, '0);
      drive_cycle(3'b101, 3'b000, {4'd2, 4'd0, 4'd1}, '0);
      drive_cycle(3'b100, 3'b000, {4'd2, 4'd0, 4'd1}, '0);
      check("drop_gnt", 32'(last_g), 32'd2);
      check("drop_ptr", 32'(dut.rr_ptr), 32'd1);
      drive_cycle('0, '0, '0, '0);

      // asynchronous reset in the middle of requester 1's burst
      do_reset();
      for (int k = 0; k < 3; k++) drive_cycle(3'b010, 3'b000, {4'd0, 4'd4, 4'd0}, '0);
      rst_n = 1'b0;
      #1;
      check("mid_rst_gnt", 32'(gnt), 32'd0);
      check("mid_rst_rvalid", 32'(rvalid), 32'd0);
      check("mid_rst_cs", 32'(mem_cs), 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive_cycle(3'b010, 3'b000, {4'd0, 4'd4, 4'd0}, '0);
      check("post_rst_gnt", 32'(last_g), 32'd1);
      drive_cycle('0, '0, '0, '0);

      // bounded wait behind a continuously requesting owner
      do_reset();
      for (int k = 0; k < 3; k++) drive_cycle(3'b001, 3'b000, {4'd0, 4'd9, 4'd8}, '0);
      waited = 0;
      for (int k = 0; k < 2 * MB; k++) begin
         drive_cycle(3'b011, 3'b000, {4'd0, 4'd9, 4'd8}, '0);
         waited++;
         if (last_g == 1) break;
      end
      check("starve_bound", (waited <= MB && last_g == 1) ? 32'd1 : 32'd0, 32'd1);
      drive_cycle('0, '0, '0, '0);

      // randomised traffic; waiting requesters hold their beat until granted
      do_reset();
      r = '0; w = '0; a = '0; d = '0;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!(r[i] && last_g != i)) begin
               r[i] = ($urandom_range(0, 99) < 60);
               w[i] = 1'($urandom);
               a[i*AW +: AW] = AW'($urandom);
               d[i*DW +: DW] = DW'($urandom);
            end
         end
         drive_cycle(r, w, a, d);
      end
      drive_cycle('0, '0, '0, '0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
